ctrl_port_bank: RTL and testbench

- Parametrised controller-port block on the CPU side of the apu wrapper. It decodes the $4016 and $4017 register pair.
- Internal shift chains are loaded from parallel button inputs. This replaces the external read-strobe handshake.
- Supports NUM_PORTS controllers; extra ports are chained four-score style behind ports 0/1.
- Returns registered read data for the CPU data mux, with open-bus upper bits.

---
 rtl/ctrl_pkg.sv | 10 +
 rtl/ctrl_port_bank_if.sv | 12 +
 rtl/ctrl_shift_chain.sv | 43 ++++
 rtl/ctrl_port_bank.sv | 59 +++++
 tb/tb_ctrl_port_bank.sv | 161 ++++++++++++++++
 5 files changed

// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared constants and chain sizing for the controller port bank
package ctrl_pkg;
  localparam logic [15:0] CTRL_ADDR0 = 16'h4016;
  localparam logic [15:0] CTRL_ADDR1 = 16'h4017;
  localparam logic [7:0] OPEN_BUS_MASK = 8'hE0;
  localparam logic FILL_BIT = 1'b1;
  function automatic int chain_len(int num_ports, int shift_bits, int sig_bits);
    return (num_ports / 2) * shift_bits + sig_bits;
  endfunction
endpackage

// File: rtl/ctrl_port_bank_if.sv
// ctrl_port_bank_if: CPU-side register access bus of the controller port bank
interface ctrl_port_bank_if;
  logic [15:0] cpu_addr_i;
  logic [7:0] cpu_data_i;
  logic cpu_rw_i;
  logic acc_en_i;
  logic [7:0] open_bus_i;
  logic [7:0] rd_data_o;
  logic rd_valid_o;
  modport master(output cpu_addr_i, cpu_data_i, cpu_rw_i, acc_en_i, open_bus_i, input rd_data_o, rd_valid_o);
  modport slave(input cpu_addr_i, cpu_data_i, cpu_rw_i, acc_en_i, open_bus_i, output rd_data_o, rd_valid_o);
endinterface

// File: rtl/ctrl_shift_chain.sv
// ctrl_shift_chain: loadable serial chain of buttons plus signature, one-filled, with saturating position
module ctrl_shift_chain
  import ctrl_pkg::*;
#(
  parameter int CHAIN = 8,
  parameter int BTN = 8,
  parameter logic [63:0] SIG = 64'd0
) (
  input logic clk,
  input logic rst_n,
  input logic load_i,
  input logic shift_i,
  input logic [BTN-1:0] btn_i,
  output logic bit0_o
);
  localparam int CW = $clog2(CHAIN + 1);
  logic [CHAIN-1:0] sr, ld;
  logic [CW-1:0] cnt;
  logic full;
  genvar i;
  for (i = 0; i < CHAIN; i++) begin : g_ld
    if (i < BTN) begin : g_btn
      assign ld[i] = btn_i[i];
    end else begin : g_sig
      assign ld[i] = SIG[i-BTN];
    end
  end
  assign full = cnt == CW'(CHAIN);
  assign bit0_o = full ? FILL_BIT : sr[0];
  // reload from parallel inputs while strobed, otherwise shift one bit per read
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr <= '1;
      cnt <= CW'(CHAIN);
    end else if (load_i) begin
      sr <= ld;
      cnt <= '0;
    end else if (shift_i) begin
      sr <= CHAIN'({FILL_BIT, sr} >> 1);
      cnt <= full ? cnt : cnt + 1'b1;
    end
  end
endmodule

// File: rtl/ctrl_port_bank.sv
// ctrl_port_bank: $4016/$4017 controller port decode, strobe latch and registered read data
module ctrl_port_bank
  import ctrl_pkg::*;
#(
  parameter int NUM_PORTS = 2,
  parameter int SHIFT_BITS = 8,
  parameter int SIG_BITS = 0,
  parameter logic [63:0] SIG0 = 64'd0,
  parameter logic [63:0] SIG1 = 64'd0,
  parameter logic [15:0] BASE_ADDR = CTRL_ADDR0
) (
  input logic clk,
  input logic rst_n,
  ctrl_port_bank_if.slave bus,
  input logic [NUM_PORTS*SHIFT_BITS-1:0] buttons_i,
  output logic [2:0] strobe_o,
  output logic [1:0] read_pulse_o
);
  localparam int CHAIN = chain_len(NUM_PORTS, SHIFT_BITS, SIG_BITS);
  localparam int BTN = CHAIN - SIG_BITS;
  logic hit0, hit1, rd, wr0, live, rbit;
  logic [1:0] rd_ch, chain_bit;
  assign hit0 = bus.cpu_addr_i == BASE_ADDR;
  assign hit1 = bus.cpu_addr_i == BASE_ADDR + 16'd1;
  assign rd = bus.acc_en_i & bus.cpu_rw_i & (hit0 | hit1);
  assign wr0 = bus.acc_en_i & ~bus.cpu_rw_i & hit0;
  assign rd_ch = {rd & hit1, rd & ~hit1};
  assign live = hit1 ? buttons_i[SHIFT_BITS] : buttons_i[0];
  assign rbit = strobe_o[0] ? live : chain_bit[hit1];
  genvar j, m;
  for (j = 0; j < 2; j++) begin : g_ch
    logic [BTN-1:0] btn;
    for (m = 0; m < NUM_PORTS / 2; m++) begin : g_port
      assign btn[m*SHIFT_BITS +: SHIFT_BITS] = buttons_i[(2*m+j)*SHIFT_BITS +: SHIFT_BITS];
    end
    ctrl_shift_chain #(.CHAIN(CHAIN), .BTN(BTN), .SIG(j == 0 ? SIG0 : SIG1)) u_chain (
      .clk(clk),
      .rst_n(rst_n),
      .load_i(strobe_o[0]),
      .shift_i(rd_ch[j] & ~strobe_o[0]),
      .btn_i(btn),
      .bit0_o(chain_bit[j])
    );
  end
  // strobe latch and one-cycle-late read response
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      strobe_o <= '0;
      bus.rd_data_o <= '0;
      bus.rd_valid_o <= 1'b0;
      read_pulse_o <= '0;
    end else begin
      if (wr0) strobe_o <= bus.cpu_data_i[2:0];
      if (rd) bus.rd_data_o <= (bus.open_bus_i & OPEN_BUS_MASK) | {7'b0, rbit};
      bus.rd_valid_o <= rd;
      read_pulse_o <= rd_ch;
    end
  end
endmodule

// File: tb/tb_ctrl_port_bank.sv
// tb_ctrl_port_bank: directed vectors against a 2-port and a 4-port signature configuration
module tb_ctrl_port_bank;
  logic clk = 1'b0;
  logic rst_n;
  logic [15:0] btn_a;
  logic [31:0] btn_b;
  logic [2:0] st_a, st_b;
  logic [1:0] rp_a, rp_b;
  logic [7:0] ob;
  int n_vec = 0;
  int n_err = 0;
  always #5 clk = ~clk;
  ctrl_port_bank_if b0 ();
  ctrl_port_bank_if b1 ();
  ctrl_port_bank u0 (
    .clk(clk), .rst_n(rst_n), .bus(b0.slave), .buttons_i(btn_a),
    .strobe_o(st_a), .read_pulse_o(rp_a)
  );
  ctrl_port_bank #(.NUM_PORTS(4), .SIG_BITS(8), .SIG0(64'h08)) u1 (
    .clk(clk), .rst_n(rst_n), .bus(b1.slave), .buttons_i(btn_b),
    .strobe_o(st_b), .read_pulse_o(rp_b)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic drive(input logic [15:0] a, input logic [7:0] d, input logic rw, input logic en);
    b0.cpu_addr_i = a; b0.cpu_data_i = d; b0.cpu_rw_i = rw; b0.acc_en_i = en; b0.open_bus_i = ob;
    b1.cpu_addr_i = a; b1.cpu_data_i = d; b1.cpu_rw_i = rw; b1.acc_en_i = en; b1.open_bus_i = ob;
  endtask
  task automatic xfer(input logic [15:0] a, input logic [7:0] d, input logic rw, input logic en);
    @(negedge clk);
    drive(a, d, rw, en);
    @(posedge clk);
    #1;
    drive(16'h0000, 8'h00, 1'b1, 1'b0);
  endtask
  task automatic rd(input logic [15:0] a);
    xfer(a, 8'h00, 1'b1, 1'b1);
  endtask
  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    xfer(a, d, 1'b0, 1'b1);
  endtask
  task automatic reload();
    wr(16'h4016, 8'h01);
    wr(16'h4016, 8'h00);
  endtask
  initial begin
    logic [7:0] seq1;
    logic [24:0] seq3;
    seq1 = 8'b1010_0101;
    seq3 = 25'b1_00001000_00000000_11111111;
    rst_n = 1'b0;
    btn_a = '0;
    btn_b = '0;
    ob = 8'h00;
    drive(16'h0000, 8'h00, 1'b1, 1'b0);
    #12;
    check("rst_data", b0.rd_data_o, 8'h00);
    check("rst_valid", b0.rd_valid_o, 1'b0);
    check("rst_strobe", st_a, 3'd0);
    check("rst_pulse", rp_a, 2'b00);
    @(negedge clk);
    rst_n = 1'b1;
    rd(16'h4016);
    check("prestrobe_read", b0.rd_data_o, 8'h01);
    btn_a = {8'h00, 8'hA5};
    wr(16'h4016, 8'h01);
    check("strobe_set", st_a, 3'd1);
    wr(16'h4016, 8'h00);
    check("strobe_clr", st_a, 3'd0);
    for (int i = 0; i < 8; i++) begin
      rd(16'h4016);
      check($sformatf("a5_bit%0d", i), b0.rd_data_o, {7'b0, seq1[i]});
      check($sformatf("a5_valid%0d", i), b0.rd_valid_o, 1'b1);
      check($sformatf("a5_pulse%0d", i), rp_a, 2'b01);
      if (i == 1) begin
        @(negedge clk);
        @(posedge clk);
        #1;
        check("idle_valid", b0.rd_valid_o, 1'b0);
        check("idle_pulse", rp_a, 2'b00);
        check("idle_hold", b0.rd_data_o, 8'h00);
      end
    end
    rd(16'h4016);
    check("a5_exhausted", b0.rd_data_o, 8'h01);
    btn_a = {8'h00, 8'h02};
    wr(16'h4016, 8'h01);
    rd(16'h4016);
    check("live_lo", b0.rd_data_o, 8'h00);
    btn_a[0] = 1'b1;
    rd(16'h4016);
    check("live_hi", b0.rd_data_o, 8'h01);
    wr(16'h4016, 8'h00);
    rd(16'h4016);
    check("after_live0", b0.rd_data_o, 8'h01);
    rd(16'h4016);
    check("after_live1", b0.rd_data_o, 8'h01);
    rd(16'h4016);
    check("after_live2", b0.rd_data_o, 8'h00);
    btn_b = {8'h00, 8'h00, 8'h00, 8'hFF};
    reload();
    for (int i = 0; i < 25; i++) begin
      rd(16'h4016);
      check($sformatf("sig_bit%0d", i), b1.rd_data_o, {7'b0, seq3[i]});
    end
    btn_a = {8'h01, 8'h00};
    reload();
    ob = 8'h40;
    rd(16'h4017);
    check("ob_4017_data", b0.rd_data_o, 8'h41);
    check("ob_4017_pulse", rp_a, 2'b10);
    ob = 8'hFF;
    rd(16'h4016);
    check("ob_mask_data", b0.rd_data_o, 8'hE0);
    check("ob_mask_pulse", rp_a, 2'b01);
    ob = 8'h00;
    btn_a = {8'h00, 8'h02};
    reload();
    xfer(16'h4016, 8'h01, 1'b0, 1'b0);
    check("wr_noacc", st_a, 3'd0);
    wr(16'h4017, 8'h01);
    check("wr_4017", st_a, 3'd0);
    xfer(16'h4016, 8'h00, 1'b1, 1'b0);
    check("rd_noacc_valid", b0.rd_valid_o, 1'b0);
    rd(16'h4016);
    check("noacc_next0", b0.rd_data_o, 8'h00);
    rd(16'h4016);
    check("noacc_next1", b0.rd_data_o, 8'h01);
    btn_a = {8'h00, 8'hA5};
    reload();
    rd(16'h4016);
    check("mid_bit0", b0.rd_data_o, 8'h01);
    rd(16'h4016);
    check("mid_bit1", b0.rd_data_o, 8'h00);
    rd(16'h4016);
    check("mid_bit2", b0.rd_data_o, 8'h01);
    wr(16'h4016, 8'h06);
    check("strobe_6", st_a, 3'd6);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_data", b0.rd_data_o, 8'h00);
    check("arst_valid", b0.rd_valid_o, 1'b0);
    check("arst_strobe", st_a, 3'd0);
    check("arst_pulse", rp_a, 2'b00);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rd(16'h4016);
      check($sformatf("post_rst%0d", i), b0.rd_data_o, 8'h01);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
